// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC/IR and the instruction-memory request/ack handshake.
// Latency: IRWr to IR/PC update is 2 cycles with a zero-wait memory, plus any memory wait cycles.
// Backpressure: fetch_busy holds the controller in its fetch state; unacked requests time out and reissue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        IRWr,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] RegA,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic        fetch_busy,
    output logic        addr_err,
    output logic [7:0]  retry_cnt
);

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JMPR   = 2'b11;
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RETRY} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        inc_pend_q, inc_pend_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        addr_err_q, addr_err_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            inc_pend_q  <= 1'b0;
            tmo_q       <= '0;
            addr_err_q  <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            inc_pend_q  <= inc_pend_d;
            tmo_q       <= tmo_d;
            addr_err_q  <= addr_err_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        inc_pend_d  = inc_pend_q;
        tmo_d       = tmo_q;
        addr_err_d  = addr_err_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            IDLE: begin
                if (IRWr) begin
                    state_d    = REQ;
                    tmo_d      = '0;
                    inc_pend_d = PCWr && (NPCOp == NPC_PLUS4);
                end else if (PCWr) begin
                    // PC already points past the current instruction, so offsets are relative to it
                    case (NPCOp)
                        NPC_BRANCH: pc_d = pc_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
                        NPC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                        NPC_JMPR: begin
                            pc_d = {RegA[31:2], 2'b00};
                            if (RegA[1:0] != 2'b00) addr_err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    if (inc_pend_q) pc_d = pc_q + 32'd4;
                    inc_pend_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RETRY;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RETRY: begin
                if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
                tmo_d   = '0;
                state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q != IDLE);
    assign IR         = ir_q;
    assign PC         = pc_q;
    assign Op         = ir_q[31:26];
    assign Funct      = ir_q[5:0];
    assign addr_err   = addr_err_q;
    assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboarded fetches with a scripted memory, a PC-write vector table,
// and hand-written sequences for busy-time writes and asynchronous reset.
module tb_fetch_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWr, IRWr;
    logic [1:0]  NPCOp;
    logic [31:0] RegA;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR, PC;
    logic [5:0]  Op, Funct;
    logic        fetch_busy, addr_err;
    logic [7:0]  retry_cnt;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RegA(RegA),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .IR(IR), .PC(PC), .Op(Op), .Funct(Funct),
        .fetch_busy(fetch_busy), .addr_err(addr_err), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] ir;
        logic [1:0]  op;
        logic [31:0] rega;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[7];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] pc_m, ir_m;
    int          rc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        @(negedge clk);
        PCWr = 1'b1; NPCOp = 2'b11; RegA = v;
        @(negedge clk);
        PCWr = 1'b0;
        pc_m = v;
    endtask

    task automatic do_fetch(input string name, input logic [31:0] rdata, input logic inc,
                            input int ack_after);
        exp_t        e;
        int          reqs, gaps, busy;
        bit          done, addr_bad, early;
        logic [31:0] ir_before;
        reqs = 0; gaps = 0; busy = 0; done = 0; addr_bad = 0; early = 0;
        ir_before = ir_m;
        @(negedge clk);
        IRWr = 1'b1; PCWr = inc; NPCOp = 2'b00;
        e.ir = rdata;
        e.pc = inc ? pc_m + 32'd4 : pc_m;
        sb.push_back(e);
        @(negedge clk);
        IRWr = 1'b0; PCWr = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (!fetch_busy) begin
                done = 1;
            end else begin
                busy++;
                if (IR !== ir_before) early = 1;
                if (imem_req) begin
                    if (imem_addr !== pc_m) addr_bad = 1;
                    if (reqs == ack_after) begin
                        imem_ack = 1'b1; imem_rdata = rdata;
                    end
                    reqs++;
                end else begin
                    gaps++;
                end
                @(negedge clk);
                imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s_timeout: fetch_busy still high after 200 cycles, expected low", name);
        end
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s_sb: scoreboard empty, expected 1 entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_ir"}, IR, e.ir);
            chk({name, "_pc"}, PC, e.pc);
            ir_m = e.ir; pc_m = e.pc;
        end
        rc_m = rc_m + ack_after / TMO;
        if (rc_m > 255) rc_m = 255;
        chk({name, "_busy"}, 32'(busy), 32'(ack_after + 1 + ack_after / TMO));
        chk({name, "_reqs"}, 32'(reqs), 32'(ack_after + 1));
        chk({name, "_gaps"}, 32'(gaps), 32'(ack_after / TMO));
        chk({name, "_addr_stable"}, {31'd0, addr_bad}, 32'd0);
        chk({name, "_ir_early"}, {31'd0, early}, 32'd0);
        chk({name, "_retry_cnt"}, {24'd0, retry_cnt}, 32'(rc_m));
    endtask

    initial begin
        vt[0] = '{32'h0000_3008, 32'h1000_FFFF, 2'b01, 32'h0,         32'h0000_3004, 1'b0};
        vt[1] = '{32'h0000_3000, 32'h1000_0004, 2'b01, 32'h0,         32'h0000_3010, 1'b0};
        vt[2] = '{32'h0000_3008, 32'h0800_0C10, 2'b10, 32'h0,         32'h0000_3040, 1'b0};
        vt[3] = '{32'hA000_0000, 32'h0800_0001, 2'b10, 32'h0,         32'hA000_0004, 1'b0};
        vt[4] = '{32'h0000_3020, 32'h0000_0000, 2'b00, 32'h0,         32'h0000_3020, 1'b0};
        vt[5] = '{32'h0000_3000, 32'h0000_0000, 2'b11, 32'h0000_3046, 32'h0000_3044, 1'b1};
        vt[6] = '{32'h0000_3100, 32'h1000_0001, 2'b01, 32'h0,         32'h0000_3104, 1'b1};

        rst = 1'b1; PCWr = 1'b0; IRWr = 1'b0; NPCOp = 2'b00; RegA = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        pc_m = 32'h0000_3000; ir_m = '0; rc_m = 0;
        repeat (2) @(negedge clk);
        chk("rst_pc", PC, 32'h0000_3000);
        chk("rst_ir", IR, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        chk("rst_retry", {24'd0, retry_cnt}, 32'd0);
        rst = 1'b0;

        do_fetch("f0", 32'h2008_0005, 1'b1, 0);
        chk("f0_op", {26'd0, Op}, 32'h08);

        set_pc(32'h0000_3000);
        do_fetch("f1", 32'h0000_0020, 1'b1, 3);
        chk("f1_funct", {26'd0, Funct}, 32'h20);

        do_fetch("f2", 32'h8C01_0004, 1'b1, TMO);

        // A stray ack while idle must not load IR
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("idle_ack_ir", IR, ir_m);
        chk("idle_ack_busy", {31'd0, fetch_busy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            set_pc(vt[i].pc0);
            do_fetch($sformatf("v%0d", i), vt[i].ir, 1'b0, 0);
            @(negedge clk);
            PCWr = 1'b1; NPCOp = vt[i].op; RegA = vt[i].rega;
            @(negedge clk);
            PCWr = 1'b0;
            pc_m = vt[i].exp_pc;
            chk($sformatf("v%0d_pc", i), PC, vt[i].exp_pc);
            chk($sformatf("v%0d_err", i), {31'd0, addr_err}, {31'd0, vt[i].exp_err});
        end

        // PC writes and IRWr during a busy fetch are ignored
        @(negedge clk);
        IRWr = 1'b1; PCWr = 1'b0;
        @(negedge clk);
        IRWr = 1'b0; PCWr = 1'b1; NPCOp = 2'b11; RegA = 32'h0000_5000;
        @(negedge clk);
        PCWr = 1'b0; IRWr = 1'b1;
        @(negedge clk);
        IRWr = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0025;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("busy_wr_pc", PC, pc_m);
        chk("busy_wr_ir", IR, 32'h0000_0025);
        chk("busy_wr_idle", {31'd0, fetch_busy}, 32'd0);

        // Asynchronous reset in the middle of a request
        set_pc(32'h0000_3010);
        @(negedge clk);
        IRWr = 1'b1;
        @(negedge clk);
        IRWr = 1'b0;
        chk("arst_pre_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc", PC, 32'h0000_3000);
        chk("arst_ir", IR, 32'h0);
        chk("arst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("arst_err", {31'd0, addr_err}, 32'd0);
        chk("arst_retry", {24'd0, retry_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_after_busy", {31'd0, fetch_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle MIPS core. It sits directly upstream of the control FSM.
- It owns the PC and IR registers and runs the instruction-memory request/acknowledge handshake.
- It presents Op and Funct to the controller, and computes next-PC from the controller's PCWr, IRWr and NPCOp strobes.
- fetch_busy tells the controller to hold its Fetch state until the instruction word has been captured.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
TIMEOUT, 16, cycles without imem_ack before a request is dropped and reissued (range 2..255)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-high
PCWr  in  1  PC write enable from controller
IRWr  in  1  IR write / fetch-start strobe from controller
NPCOp  in  2  next-PC select: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JMPR
RegA  in  32  rs register value, used as the JMPR target
imem_req  out  1  instruction-memory request
imem_addr  out  32  instruction-memory word address (equals PC)
imem_ack  in  1  memory acknowledge; imem_rdata is valid in the same cycle
imem_rdata  in  32  instruction word
IR  out  32  instruction register
PC  out  32  program counter; also the link value for jal
Op  out  6  IR[31:26]
Funct  out  6  IR[5:0]
fetch_busy  out  1  fetch in progress; the controller stalls while this is high
addr_err  out  1  sticky flag: a JMPR target was misaligned
retry_cnt  out  8  saturating count of timeout reissues

Behaviour:
- Reset values: PC=RESET_PC, IR=0, imem_req=0, fetch_busy=0, addr_err=0, retry_cnt=0, state=IDLE, timeout counter=0.
- Reset asserted mid-fetch aborts the fetch immediately and asynchronously: imem_req goes low, and IR and PC are not updated.
- FSM states: IDLE, REQ, RETRY. All outputs are Moore outputs; imem_req=1 only in REQ; fetch_busy=1 whenever the state is not IDLE.
- IDLE:
  - IRWr=1 goes to REQ.
  - A PLUS4 increment is pending if PCWr=1 and NPCOp=PLUS4 in the same cycle.
  - IRWr=1 with PCWr=0 fetches without incrementing the PC.
- REQ:
  - imem_addr=PC, held stable until ack.
  - On imem_ack=1: IR<=imem_rdata; if the increment is pending, PC<=PC+4 (32-bit wrap, no flag); return to IDLE.
  - Otherwise the timeout counter increments; when it reaches TIMEOUT-1 without ack, go to RETRY.
- RETRY: imem_req=0 for exactly one cycle; retry_cnt+1 (saturates at 255); timeout counter cleared; return to REQ.
- An imem_ack arriving in IDLE or RETRY is ignored.
- Zero-wait memory:
  - IRWr at edge T sets req high in cycle T+1.
  - Ack in T+1 gives IR/PC updated at edge T+2.
  - fetch_busy is low in cycle T+2. Minimum fetch latency is 2 cycles.
- PC writes other than PLUS4 are accepted only in IDLE with IRWr=0, and take effect at the next edge. PC here already points at the instruction after the current one.
  - BRANCH: PC <= PC + (signext(IR[15:0]) << 2).
  - JUMP: PC <= {PC[31:28], IR[25:0], 2'b00}.
  - JMPR: PC <= {RegA[31:2], 2'b00}; if RegA[1:0] != 0, set addr_err (sticky until reset).
  - PCWr=1 with NPCOp=PLUS4 and IRWr=0: no effect.
- While busy (REQ or RETRY), IRWr and PCWr are ignored.
- Op and Funct are continuous slices of IR.

Test Plan:
- Reset, then IRWr+PCWr+PLUS4 with ack in the first REQ cycle and rdata=32'h2008_0005 -> IR=32'h2008_0005, PC=32'h0000_3004, Op=6'h08, fetch_busy high for exactly 1 cycle.
- Ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr=32'h0000_3000 stable; IR and PC update only after the ack edge.
- No ack for 16 cycles, ack on the 2nd attempt -> one cycle with req low, retry_cnt=1, fetch completes normally.
- IR=32'h1000_FFFF, PC=32'h0000_3008, BRANCH -> PC=32'h0000_3004. IR=32'h0800_0C10, JUMP -> PC=32'h0000_3040.
- JMPR with RegA=32'h0000_3046 -> PC=32'h0000_3044, addr_err=1 and stays 1. PCWr+JMPR applied while in REQ -> PC unchanged.
- rst pulsed high while in REQ at PC=32'h0000_3010 -> imem_req=0 immediately, PC=32'h0000_3000, IR=0, state IDLE.
